serial_word_comparator: RTL and testbench

//  Multi-cycle magnitude comparator for WIDTH-bit unsigned words; sits directly upstream of

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/serial_word_comparator_if.sv | 27 ++
 rtl/comparator_2bit.sv | 18 +
 rtl/serial_word_comparator.sv | 111 +++++++++++
 tb/tb_serial_word_comparator.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial word comparator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cmp_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
        logic ge;
        logic le;
    } flags_t;

endpackage

// File: rtl/serial_word_comparator_if.sv
// Request/result bundle between a requester and the serial word comparator.
// Latency: none (wiring only).
// Backpressure: start is only honoured while busy is low.
interface serial_word_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             ge;
    logic             le;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt, ge, le
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt, ge, le
    );
endinterface

// File: rtl/comparator_2bit.sv
// Combinational magnitude compare of two 2-bit unsigned values.
// Latency: zero cycles.
// Backpressure: none.
module comparator_2bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       eq_o,
    output logic       gt_o,
    output logic       lt_o,
    output logic       ge_o,
    output logic       le_o
);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);
    assign ge_o = (a_i >= b_i);
    assign le_o = (a_i <= b_i);
endmodule

// File: rtl/serial_word_comparator.sv
// Compares two WIDTH-bit unsigned words one 2-bit slice per cycle, MSB slice first.
// Latency: 1..NSLICE cycles from start to the done pulse (early exit on first unequal slice).
// Backpressure: start is ignored while busy; operands are captured at start.
module serial_word_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    serial_word_comparator_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    flags_t             flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic slice_eq, slice_gt, slice_lt, slice_ge, slice_le;
    logic last_slice;
    logic resolve;

    comparator_2bit u_slice_cmp (
        .a_i  (a_q[WIDTH-1 -: SLICE_W]),
        .b_i  (b_q[WIDTH-1 -: SLICE_W]),
        .eq_o (slice_eq),
        .gt_o (slice_gt),
        .lt_o (slice_lt),
        .ge_o (slice_ge),
        .le_o (slice_le)
    );

    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));
    assign resolve    = slice_gt | slice_lt | last_slice;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CMP;
            CMP:     if (resolve)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On the resolving slice the slice flags are the word flags: an unequal slice
    // decides everything, and the last slice is only reached with all others equal.
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d    = bus.a;
                    b_d    = bus.b;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            CMP: begin
                if (resolve) begin
                    flags_d = '{eq: slice_eq, gt: slice_gt, lt: slice_lt,
                                ge: slice_ge, le: slice_le};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    a_d   = a_q << SLICE_W;
                    b_d   = b_q << SLICE_W;
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.eq   = flags_q.eq;
    assign bus.gt   = flags_q.gt;
    assign bus.lt   = flags_q.lt;
    assign bus.ge   = flags_q.ge;
    assign bus.le   = flags_q.le;
endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator at WIDTH=8.
module tb_serial_word_comparator;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    localparam logic [4:0] F_ZERO = 5'b00000;  // {eq,gt,lt,ge,le}
    localparam logic [4:0] F_EQ   = 5'b10011;
    localparam logic [4:0] F_GT   = 5'b01010;
    localparam logic [4:0] F_LT   = 5'b00101;

    serial_word_comparator_if #(.WIDTH(8)) bus ();

    serial_word_comparator #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {bus.eq, bus.gt, bus.lt, bus.ge, bus.le};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one compare, then count edges until done; check latency, flags, one-cycle pulse.
    task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input int exp_lat, input logic [4:0] exp_f);
        int n;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_flags"}, 32'(flags()), 32'(exp_f));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_flags_hold"}, 32'(flags()), 32'(exp_f));
    endtask

    initial begin
        int n;
        int ndone;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // 1. reset with random stimulus
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
            tick();
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_flags", 32'(flags()), 32'(F_ZERO));
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_flags", 32'(flags()), 32'(F_ZERO));
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // 2..4 plus extra early-exit positions, back to back
        run_cmp("eq_A5", 8'hA5, 8'hA5, 4, F_EQ);
        run_cmp("gt_C0_40", 8'hC0, 8'h40, 1, F_GT);
        run_cmp("lt_12_13", 8'h12, 8'h13, 4, F_LT);
        run_cmp("lt_24_34", 8'h24, 8'h34, 2, F_LT);
        run_cmp("gt_0C_08", 8'h0C, 8'h08, 3, F_GT);
        run_cmp("eq_00", 8'h00, 8'h00, 4, F_EQ);

        // 5. start held high, operands changed while busy, restart in done cycle
        bus.start = 1'b1;
        bus.a     = 8'h30;
        bus.b     = 8'h31;
        tick();
        bus.a = 8'hFF;
        bus.b = 8'h00;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("hold_no_early_done", 32'(ndone), 32'd0);
        tick();
        chk("hold_done", 32'(bus.done), 32'd1);
        chk("hold_flags_lt", 32'(flags()), 32'(F_LT));
        bus.a = 8'h01;
        bus.b = 8'h00;
        tick();
        bus.start = 1'b0;
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_done_low", 32'(bus.done), 32'd0);
        chk("restart_flags_held", 32'(flags()), 32'(F_LT));
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("restart_done_seen", 32'(bus.done), 32'd1);
        chk("restart_latency", 32'(n), 32'd4);
        chk("restart_flags_gt", 32'(flags()), 32'(F_GT));
        tick();

        // 6. asynchronous abort mid-compare
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h13;
        tick();
        bus.start = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_flags", 32'(flags()), 32'(F_ZERO));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_flags_after", 32'(flags()), 32'(F_ZERO));
        run_cmp("gt_FF_FE", 8'hFF, 8'hFE, 4, F_GT);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
